mppt_tracker: RTL and testbench

Parametrised MPPT control-value generator for the beacon PV front end. It replaces the fixed 8/10-bit voltage-window stepper with configurable widths, a prescaled update tick, and two selectable tracking modes: voltage-window and perturb-and-observe (P&O). It also provides hysteretic capacitor and power status flags to the top-level state machine. It sits between the ADC sampling logic and the SMPS PWM generators.

---
 rtl/mppt_tracker.sv | 183 ++++++++++++++++++
 tb/tb_mppt_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mppt_tracker.sv
// MPPT control-value generator: prescaled voltage-window or perturb-and-observe
// stepping of a saturated duty value, plus hysteretic capacitor/power status flags.
module mppt_tracker #(
  parameter int DATA_W   = 8,
  parameter int VAL_W    = 10,
  parameter int VAL_INIT = 500,
  parameter int VAL_MIN  = 1,
  parameter int VAL_MAX  = 1022,
  parameter int STEP     = 1,
  parameter int PRESCALE = 1024,
  parameter int V_HI     = 190,
  parameter int V_LO     = 175,
  parameter int CAP_CHG  = 128,
  parameter int CAP_5    = 71,
  parameter int CAP_7    = 110,
  parameter int P_HIGH   = 7000,
  parameter int HYST     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   V_panel,
  input  logic [DATA_W-1:0]   I_panel,
  input  logic [DATA_W-1:0]   V_cap,
  input  logic [2:0]          state_number,
  input  logic                mode,
  output logic [VAL_W-1:0]    val,
  output logic                val_update,
  output logic                dir_up,
  output logic [2*DATA_W-1:0] p_in,
  output logic                cap_charged,
  output logic                cap_over5,
  output logic                PV_power_high,
  output logic                pwr_low
);

  localparam int P_W   = 2 * DATA_W;
  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [P_W-1:0] CHG_SET = P_W'(CAP_CHG);
  localparam logic [P_W-1:0] CHG_CLR = P_W'(CAP_CHG - HYST);
  localparam logic [P_W-1:0] C5_SET  = P_W'(CAP_5);
  localparam logic [P_W-1:0] C5_CLR  = P_W'(CAP_5 - HYST);
  localparam logic [P_W-1:0] C7_SET  = P_W'(CAP_7);
  localparam logic [P_W-1:0] C7_CLR  = P_W'(CAP_7 - HYST);
  localparam logic [P_W-1:0] PH_SET  = P_W'(P_HIGH);
  localparam logic [P_W-1:0] PH_CLR  = P_W'(P_HIGH - HYST);

  localparam logic signed [VAL_W+1:0] MAX_S  = (VAL_W+2)'(VAL_MAX);
  localparam logic signed [VAL_W+1:0] MIN_S  = (VAL_W+2)'(VAL_MIN);
  localparam logic signed [VAL_W+1:0] STEP_S = (VAL_W+2)'(STEP);

  // One step in the given direction, clamped in a widened signed domain so
  // neither end can wrap around.
  function automatic logic [VAL_W-1:0] sat_step(input logic [VAL_W-1:0] cur,
                                                 input logic up);
    logic signed [VAL_W+1:0] t;
    t = $signed({2'b00, cur});
    t = up ? (t + STEP_S) : (t - STEP_S);
    if (t > MAX_S) t = MAX_S;
    if (t < MIN_S) t = MIN_S;
    return t[VAL_W-1:0];
  endfunction

  function automatic logic hyst(input logic [P_W-1:0] x,
                                input logic [P_W-1:0] set_thr,
                                input logic [P_W-1:0] clr_thr,
                                input logic cur);
    if (x > set_thr)      return 1'b1;
    else if (x < clr_thr) return 1'b0;
    else                  return cur;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              have_sample;
  logic [DATA_W-1:0] v_panel_p1;
  logic [P_W-1:0]    p_next;
  logic [P_W-1:0]    vcap_ext;
  logic [P_W-1:0]    prev_p;
  logic              prev_valid;
  logic [2:0]        state_q;
  logic              mode_q;
  logic              cap_over7;
  logic              track;
  logic              changed;
  logic              upd_en;
  logic [VAL_W-1:0]  val_next;
  logic              dir_next;
  logic              prev_valid_next;
  logic              chg_n, c5_n, c7_n, ph_n;

  assign tick     = (cnt == CNT_W'(PRESCALE - 1));
  assign p_next   = {{DATA_W{1'b0}}, V_panel} * {{DATA_W{1'b0}}, I_panel};
  assign vcap_ext = {{DATA_W{1'b0}}, V_cap};

  always_comb begin
    chg_n = hyst(vcap_ext, CHG_SET, CHG_CLR, cap_charged);
    c5_n  = hyst(vcap_ext, C5_SET,  C5_CLR,  cap_over5);
    c7_n  = hyst(vcap_ext, C7_SET,  C7_CLR,  cap_over7);
    ph_n  = hyst(p_next,   PH_SET,  PH_CLR,  PV_power_high);
  end

  // Tracking decision; a state or mode change restarts P&O before any step.
  always_comb begin
    track           = (state_number == 3'd1) || (state_number == 3'd2) ||
                      (state_number == 3'd3);
    changed         = (state_number != state_q) || (mode != mode_q);
    upd_en          = tick && have_sample && track && !changed;
    val_next        = val;
    dir_next        = dir_up;
    prev_valid_next = prev_valid;
    if (changed) begin
      dir_next        = 1'b1;
      prev_valid_next = 1'b0;
    end else if (upd_en) begin
      if (!mode) begin
        if (v_panel_p1 > DATA_W'(V_HI))      val_next = sat_step(val, 1'b1);
        else if (v_panel_p1 < DATA_W'(V_LO)) val_next = sat_step(val, 1'b0);
      end else begin
        prev_valid_next = 1'b1;
        if (!prev_valid || (p_in > prev_p)) begin
          val_next = sat_step(val, dir_up);
        end else if (p_in < prev_p) begin
          dir_next = !dir_up;
          val_next = sat_step(val, !dir_up);
        end
        if (val_next == VAL_W'(VAL_MAX))      dir_next = 1'b0;
        else if (val_next == VAL_W'(VAL_MIN)) dir_next = 1'b1;
      end
    end
  end

  // Stage p0 -> p1: sample capture and status flags
  always_ff @(posedge clk) begin
    if (sample_valid) v_panel_p1 <= V_panel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_in          <= '0;
      cap_charged   <= 1'b0;
      cap_over5     <= 1'b0;
      cap_over7     <= 1'b0;
      PV_power_high <= 1'b0;
      pwr_low       <= 1'b0;
    end else if (sample_valid) begin
      p_in          <= p_next;
      cap_charged   <= chg_n;
      cap_over5     <= c5_n;
      cap_over7     <= c7_n;
      PV_power_high <= ph_n;
      pwr_low       <= ~ph_n & ~c7_n;
    end
  end

  // Stage p1 -> output: prescaler and control value update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      have_sample <= 1'b0;
      val         <= VAL_W'(VAL_INIT);
      val_update  <= 1'b0;
      dir_up      <= 1'b1;
      prev_valid  <= 1'b0;
      prev_p      <= '0;
      state_q     <= 3'd0;
      mode_q      <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)              have_sample <= sample_valid;
      else if (sample_valid) have_sample <= 1'b1;
      val        <= val_next;
      val_update <= (val_next != val);
      dir_up     <= dir_next;
      prev_valid <= prev_valid_next;
      if (upd_en && mode) prev_p <= p_in;
      state_q    <= state_number;
      mode_q     <= mode;
    end
  end

endmodule

// File: tb/tb_mppt_tracker.sv
// Directed bench for mppt_tracker: scoreboard of expected update results,
// plus direct flag/product checks after each sample.
module tb_mppt_tracker;

  localparam int PS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  V_panel = '0, I_panel = '0, V_cap = '0;
  logic [2:0]  state_number = 3'd0, state_s = 3'd0;
  logic        mode = 1'b0, mode_s = 1'b0;

  logic [9:0]  val, val_s;
  logic        val_update, val_update_s, dir_up, dir_up_s;
  logic [15:0] p_in, p_in_s;
  logic        cap_charged, cap_over5, PV_power_high, pwr_low;
  logic        cap_charged_s, cap_over5_s, PV_power_high_s, pwr_low_s;

  mppt_tracker #(.PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .V_panel(V_panel), .I_panel(I_panel), .V_cap(V_cap),
    .state_number(state_number), .mode(mode),
    .val(val), .val_update(val_update), .dir_up(dir_up), .p_in(p_in),
    .cap_charged(cap_charged), .cap_over5(cap_over5),
    .PV_power_high(PV_power_high), .pwr_low(pwr_low)
  );

  mppt_tracker #(.PRESCALE(PS), .VAL_INIT(1021)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .V_panel(V_panel), .I_panel(I_panel), .V_cap(V_cap),
    .state_number(state_s), .mode(mode_s),
    .val(val_s), .val_update(val_update_s), .dir_up(dir_up_s), .p_in(p_in_s),
    .cap_charged(cap_charged_s), .cap_over5(cap_over5_s),
    .PV_power_high(PV_power_high_s), .pwr_low(pwr_low_s)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: value equals the DUT counter between edges.
  logic [2:0] tb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= (tb_cnt == 3'(PS - 1)) ? 3'd0 : tb_cnt + 3'd1;
  end

  typedef struct {
    logic [9:0] val;
    logic       upd;
    logic       dir;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Sample two cycles before a tick, then check the update that tick produces.
  task automatic step(input string tag, input bit sat,
                      input logic [7:0] vp, input logic [7:0] ip, input logic [7:0] vc,
                      input logic [9:0] ev, input logic eu, input logic ed);
    exp_t e;
    bit found = 0;
    for (int i = 0; i < 4 * PS && !found; i++) begin
      @(negedge clk);
      if (tb_cnt == 3'(PS - 3)) found = 1;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    V_panel = vp; I_panel = ip; V_cap = vc; sample_valid = 1'b1;
    sb.push_back('{val: ev, upd: eu, dir: ed});
    @(negedge clk);
    sample_valid = 1'b0;
    chk({tag, "_p_in"}, 32'(sat ? p_in_s : p_in), 32'(vp) * 32'(ip));
    @(negedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_val"}, 32'(sat ? val_s : val), 32'(e.val));
      chk({tag, "_upd"}, 32'(sat ? val_update_s : val_update), 32'(e.upd));
      chk({tag, "_dir"}, 32'(sat ? dir_up_s : dir_up), 32'(e.dir));
    end
  endtask

  task automatic sample_flags(input string tag,
                              input logic [7:0] vp, input logic [7:0] ip, input logic [7:0] vc,
                              input logic ec, input logic e5, input logic eph, input logic epl);
    @(negedge clk);
    V_panel = vp; I_panel = ip; V_cap = vc; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk({tag, "_chg"}, 32'(cap_charged), 32'(ec));
    chk({tag, "_c5"}, 32'(cap_over5), 32'(e5));
    chk({tag, "_ph"}, 32'(PV_power_high), 32'(eph));
    chk({tag, "_plow"}, 32'(pwr_low), 32'(epl));
    chk({tag, "_p_in"}, 32'(p_in), 32'(vp) * 32'(ip));
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_val", 32'(val), 32'd500);
    chk("rst_upd", 32'(val_update), 32'd0);
    chk("rst_dir", 32'(dir_up), 32'd1);
    chk("rst_p_in", 32'(p_in), 32'd0);
    chk("rst_flags", {28'd0, cap_charged, cap_over5, PV_power_high, pwr_low}, 32'd0);
    chk("rst_sat_val", 32'(val_s), 32'd1021);
    rst_n = 1'b1;
    state_number = 3'd1;
    mode = 1'b0;

    // Window mode
    step("win200a", 0, 8'd200, 8'd10, 8'd0, 10'd501, 1'b1, 1'b1);
    step("win200b", 0, 8'd200, 8'd10, 8'd0, 10'd502, 1'b1, 1'b1);
    step("win200c", 0, 8'd200, 8'd10, 8'd0, 10'd503, 1'b1, 1'b1);
    step("win180",  0, 8'd180, 8'd10, 8'd0, 10'd503, 1'b0, 1'b1);
    step("win170",  0, 8'd170, 8'd10, 8'd0, 10'd502, 1'b1, 1'b1);

    // Perturb and observe
    state_number = 3'd2;
    mode = 1'b1;
    step("po1000", 0, 8'd100, 8'd10, 8'd0, 10'd503, 1'b1, 1'b1);
    step("po1200", 0, 8'd100, 8'd12, 8'd0, 10'd504, 1'b1, 1'b1);
    step("po1100", 0, 8'd100, 8'd11, 8'd0, 10'd503, 1'b1, 1'b0);
    step("po1100e", 0, 8'd100, 8'd11, 8'd0, 10'd503, 1'b0, 1'b0);

    // Hold state: val frozen while p_in keeps tracking
    state_number = 3'd4;
    for (int k = 0; k < 5; k++)
      step("hold", 0, 8'd200, 8'(10 + k), 8'd0, 10'd503, 1'b0, 1'b1);

    // Hysteresis on capacitor and power flags
    sample_flags("cap120", 8'd100, 8'd10, 8'd120, 1'b0, 1'b1, 1'b0, 1'b0);
    sample_flags("cap130", 8'd100, 8'd10, 8'd130, 1'b1, 1'b1, 1'b0, 1'b0);
    sample_flags("cap126", 8'd100, 8'd10, 8'd126, 1'b1, 1'b1, 1'b0, 1'b0);
    sample_flags("cap123", 8'd100, 8'd10, 8'd123, 1'b0, 1'b1, 1'b0, 1'b0);
    sample_flags("p7200",  8'd180, 8'd40, 8'd123, 1'b0, 1'b1, 1'b1, 1'b0);
    sample_flags("p7000",  8'd200, 8'd35, 8'd123, 1'b0, 1'b1, 1'b1, 1'b0);
    sample_flags("p6000",  8'd100, 8'd60, 8'd123, 1'b0, 1'b1, 1'b0, 1'b0);
    sample_flags("cap100", 8'd100, 8'd60, 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);
    sample_flags("cap68",  8'd100, 8'd60, 8'd68,  1'b0, 1'b1, 1'b0, 1'b1);
    sample_flags("cap66",  8'd100, 8'd60, 8'd66,  1'b0, 1'b0, 1'b0, 1'b1);

    // Saturation at VAL_MAX on the second instance
    state_s = 3'd1;
    mode_s = 1'b0;
    step("sat1", 1, 8'd255, 8'd10, 8'd100, 10'd1022, 1'b1, 1'b1);
    step("sat2", 1, 8'd255, 8'd10, 8'd100, 10'd1022, 1'b0, 1'b1);
    step("sat3", 1, 8'd255, 8'd10, 8'd100, 10'd1022, 1'b0, 1'b1);
    step("sat4", 1, 8'd255, 8'd10, 8'd100, 10'd1022, 1'b0, 1'b1);
    mode_s = 1'b1;
    step("sat_po1", 1, 8'd255, 8'd10, 8'd100, 10'd1022, 1'b0, 1'b0);
    step("sat_po2", 1, 8'd255, 8'd20, 8'd100, 10'd1021, 1'b1, 1'b0);

    // Return to tracking: P&O restarts with an upward step
    state_number = 3'd3;
    @(negedge clk);
    chk("ret_dir", 32'(dir_up), 32'd1);
    step("ret_po", 0, 8'd100, 8'd10, 8'd100, 10'd504, 1'b1, 1'b1);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_val", 32'(val), 32'd500);
    chk("async_dir", 32'(dir_up), 32'd1);
    chk("async_p_in", 32'(p_in), 32'd0);
    chk("async_flags", {28'd0, cap_charged, cap_over5, PV_power_high, pwr_low}, 32'd0);
    chk("async_sat_val", 32'(val_s), 32'd1021);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
